pipe_stage_reg: RTL and testbench

- Generic, parametrised inter-stage pipeline register for the MIPS32 pipeline (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Replaces hand-written per-stage latches with one valid/ready-handshaked block.
- Supports stall back-pressure, synchronous flush (branch/exception squash), bubble insertion with forced-safe control fields, an optional 2-entry skid mode, and a saturating stall counter for performance monitoring.

---
 rtl/pipe_stage_reg_pkg.sv | 29 ++
 rtl/pipe_stage_reg_stall_counter.sv | 39 +++
 rtl/pipe_stage_reg.sv | 154 +++++++++++++++
 tb/tb_pipe_stage_reg.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_stage_reg_pkg.sv
// Shared definitions for the MIPS32 inter-stage pipeline registers:
// occupancy encodings, control-field layout and per-stage safe control words.
package pipe_stage_reg_pkg;

   typedef enum logic [1:0] {
      OCC_EMPTY = 2'd0,
      OCC_ONE   = 2'd1,
      OCC_TWO   = 2'd2
   } occ_e;

   // Control word layout: aluop, reg_wr, mem_wr, waddr, type, to_pc, to_hilo
   localparam int CTRL_AOP_LSB    = 0;
   localparam int CTRL_AOP_W      = 5;
   localparam int CTRL_REGWR_BIT  = 5;
   localparam int CTRL_MEMWR_BIT  = 6;
   localparam int CTRL_WADDR_LSB  = 7;
   localparam int CTRL_WADDR_W    = 5;
   localparam int CTRL_TYPE_LSB   = 12;
   localparam int CTRL_TYPE_W     = 2;
   localparam int CTRL_TOPC_BIT   = 14;
   localparam int CTRL_TOHILO_BIT = 15;

   // A bubble must never write a register, memory, PC or hi/lo
   localparam logic [15:0] CTRL_SAFE_IFID  = 16'h0000;
   localparam logic [15:0] CTRL_SAFE_IDEX  = 16'h0000;
   localparam logic [15:0] CTRL_SAFE_EXMEM = 16'h0000;
   localparam logic [15:0] CTRL_SAFE_MEMWB = 16'h0000;

endpackage

// File: rtl/pipe_stage_reg_stall_counter.sv
// Saturating up-counter with synchronous clear (clear beats enable);
// usable for any performance-monitor event.
module pipe_stage_reg_stall_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         en,
   output logic [W-1:0] count
);

   logic [W-1:0] count_q;
   logic [W-1:0] count_d;

   // next count: clear, saturating increment, or hold
   always_comb begin
      count_d = count_q;
      if (clr) begin
         count_d = {W{1'b0}};
      end else if (en && (count_q != {W{1'b1}})) begin
         count_d = count_q + {{(W-1){1'b0}}, 1'b1};
      end else begin
         count_d = count_q;
      end
   end

   // counter register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q <= {W{1'b0}};
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline register between MIPS32 stages with flush, bubble
// control forcing, optional two-entry skid buffer and a stall counter.
module pipe_stage_reg
   import pipe_stage_reg_pkg::*;
#(
   parameter int                DATA_W    = 96,
   parameter int                CTRL_W    = 16,
   parameter logic [CTRL_W-1:0] CTRL_SAFE = {CTRL_W{1'b0}},
   parameter int                SKID      = 1,
   parameter int                CNT_W     = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic [CTRL_W-1:0] in_ctrl,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [1:0]        occupancy,
   output logic [CNT_W-1:0]  stall_cnt,
   input  logic              stall_cnt_clr
);

   localparam bit SKID_EN = (SKID != 32'sd0);

   occ_e              state_q;
   occ_e              state_d;
   logic              in_ready_q;
   logic              in_ready_d;
   logic [DATA_W-1:0] main_data_q;
   logic [DATA_W-1:0] main_data_d;
   logic [CTRL_W-1:0] main_ctrl_q;
   logic [CTRL_W-1:0] main_ctrl_d;
   logic [CTRL_W-1:0] main_ctrl_nxt;
   logic [DATA_W-1:0] skid_data_q;
   logic [DATA_W-1:0] skid_data_d;
   logic [CTRL_W-1:0] skid_ctrl_q;
   logic [CTRL_W-1:0] skid_ctrl_d;
   logic              accept;
   logic              consume;

   assign out_valid = (state_q != OCC_EMPTY);
   assign accept    = in_valid & in_ready;
   assign consume   = out_valid & out_ready;

   // state, ready and payload registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= OCC_EMPTY;
         in_ready_q  <= 1'b1;
         main_data_q <= {DATA_W{1'b0}};
         main_ctrl_q <= CTRL_SAFE;
         skid_data_q <= {DATA_W{1'b0}};
         skid_ctrl_q <= CTRL_SAFE;
      end else begin
         state_q     <= state_d;
         in_ready_q  <= in_ready_d;
         main_data_q <= main_data_d;
         main_ctrl_q <= main_ctrl_d;
         skid_data_q <= skid_data_d;
         skid_ctrl_q <= skid_ctrl_d;
      end
   end

   // next occupancy; flush squashes everything including a same-cycle accept
   always_comb begin
      state_d = state_q;
      if (flush) begin
         state_d = OCC_EMPTY;
      end else begin
         case (state_q)
            OCC_EMPTY: begin
               if (accept) state_d = OCC_ONE;
               else        state_d = OCC_EMPTY;
            end
            OCC_ONE: begin
               if (accept && !consume && SKID_EN) state_d = OCC_TWO;
               else if (!accept && consume)       state_d = OCC_EMPTY;
               else                               state_d = OCC_ONE;
            end
            OCC_TWO: begin
               if (consume) state_d = OCC_ONE;
               else         state_d = OCC_TWO;
            end
            default: state_d = OCC_EMPTY;
         endcase
      end
      in_ready_d = (state_d != OCC_TWO);
   end

   // payload movement: main feeds out_*, skid catches the overflow entry
   always_comb begin
      main_data_d   = main_data_q;
      main_ctrl_nxt = main_ctrl_q;
      skid_data_d   = skid_data_q;
      skid_ctrl_d   = skid_ctrl_q;
      if (flush) begin
         main_ctrl_nxt = CTRL_SAFE;
      end else begin
         case (state_q)
            OCC_EMPTY: begin
               if (accept) begin
                  main_data_d   = in_data;
                  main_ctrl_nxt = in_ctrl;
               end else begin
                  main_ctrl_nxt = main_ctrl_q;
               end
            end
            OCC_ONE: begin
               if (accept && consume) begin
                  main_data_d   = in_data;
                  main_ctrl_nxt = in_ctrl;
               end else if (accept) begin
                  skid_data_d = in_data;
                  skid_ctrl_d = in_ctrl;
               end else begin
                  main_ctrl_nxt = main_ctrl_q;
               end
            end
            OCC_TWO: begin
               if (consume) begin
                  main_data_d   = skid_data_q;
                  main_ctrl_nxt = skid_ctrl_q;
               end else begin
                  main_ctrl_nxt = main_ctrl_q;
               end
            end
            default: main_ctrl_nxt = CTRL_SAFE;
         endcase
      end
      // registered bubble forcing keeps out_ctrl glitch-free
      main_ctrl_d = (state_d == OCC_EMPTY) ? CTRL_SAFE : main_ctrl_nxt;
   end

   assign in_ready  = SKID_EN ? in_ready_q : (!out_valid || out_ready);
   assign out_data  = main_data_q;
   assign out_ctrl  = main_ctrl_q;
   assign occupancy = state_q;

   pipe_stage_reg_stall_counter #(
      .W (CNT_W)
   ) u_stall_counter (
      .clk   (clk),
      .rst   (rst),
      .clr   (stall_cnt_clr),
      .en    (out_valid & ~out_ready),
      .count (stall_cnt)
   );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: directed vector table, hand sequences for
// saturation and async reset, and random traffic against a queue model.
module tb_pipe_stage_reg;
   localparam int DW = 96;
   localparam int CW = 16;

   typedef struct {
      logic       fl, iv;
      logic [7:0] d;
      logic       ordy, clr;
      logic       ev;
      logic [7:0] ed;
      logic [1:0] eocc;
      logic       erdy;
      logic [15:0] est;
   } vec_t;

   typedef struct packed {
      logic [DW-1:0] d;
      logic [CW-1:0] c;
   } ent_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   logic a_flush, a_iv, a_ordy, a_clr;
   logic [DW-1:0] a_din;
   logic [CW-1:0] a_cin;
   logic a_ir, a_ov, c_ir, c_ov, b_ir, b_ov;
   logic [DW-1:0] a_dout, c_dout, b_dout;
   logic [CW-1:0] a_cout, c_cout, b_cout;
   logic [1:0] a_occ, c_occ, b_occ;
   logic [15:0] a_st, b_st;
   logic [3:0] c_st;
   logic b_flush, b_iv, b_ordy, b_clr;
   logic [DW-1:0] b_din;
   logic [CW-1:0] b_cin;

   int n_vec = 0;
   int n_err = 0;

   pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID(1), .CNT_W(16)) u_s1 (
      .clk(clk), .rst(rst), .flush(a_flush), .in_valid(a_iv), .in_ready(a_ir),
      .in_data(a_din), .in_ctrl(a_cin), .out_valid(a_ov), .out_ready(a_ordy),
      .out_data(a_dout), .out_ctrl(a_cout), .occupancy(a_occ), .stall_cnt(a_st),
      .stall_cnt_clr(a_clr));

   pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID(1), .CNT_W(4)) u_c4 (
      .clk(clk), .rst(rst), .flush(a_flush), .in_valid(a_iv), .in_ready(c_ir),
      .in_data(a_din), .in_ctrl(a_cin), .out_valid(c_ov), .out_ready(a_ordy),
      .out_data(c_dout), .out_ctrl(c_cout), .occupancy(c_occ), .stall_cnt(c_st),
      .stall_cnt_clr(a_clr));

   pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID(0), .CNT_W(16)) u_s0 (
      .clk(clk), .rst(rst), .flush(b_flush), .in_valid(b_iv), .in_ready(b_ir),
      .in_data(b_din), .in_ctrl(b_cin), .out_valid(b_ov), .out_ready(b_ordy),
      .out_data(b_dout), .out_ctrl(b_cout), .occupancy(b_occ), .stall_cnt(b_st),
      .stall_cnt_clr(b_clr));

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic drive_a(input logic fl, iv, input logic [7:0] d, input logic ordy, clr);
      a_flush = fl; a_iv = iv; a_din = {12{d}}; a_cin = {8'hC3, d}; a_ordy = ordy; a_clr = clr;
   endtask

   function automatic vec_t mk(input logic fl, iv, input logic [7:0] d, input logic ordy, clr,
                               input logic ev, input logic [7:0] ed, input logic [1:0] eocc,
                               input logic erdy, input logic [15:0] est);
      vec_t v;
      v.fl = fl; v.iv = iv; v.d = d; v.ordy = ordy; v.clr = clr;
      v.ev = ev; v.ed = ed; v.eocc = eocc; v.erdy = erdy; v.est = est;
      return v;
   endfunction

   vec_t tbl[$];
   ent_t qa[$];
   ent_t qb[$];
   logic [15:0] sa, sb;
   logic [3:0]  sc;
   logic ev, er;

   initial begin
      // streaming 1..8, downstream always ready
      for (int i = 0; i < 10; i++) begin
         logic v;
         v = (i >= 1) && (i <= 8);
         tbl.push_back(mk(1'b0, (i < 8), (i < 8) ? 8'(i + 1) : 8'h00, 1'b1, 1'b0,
                          v, v ? 8'(i) : 8'h00, v ? 2'd1 : 2'd0, 1'b1, 16'd0));
      end
      // back-pressure A, B, C
      tbl.push_back(mk(1'b0, 1'b1, 8'h0A, 1'b0, 1'b0, 1'b0, 8'h00, 2'd0, 1'b1, 16'd0));
      tbl.push_back(mk(1'b0, 1'b1, 8'h0B, 1'b0, 1'b0, 1'b1, 8'h0A, 2'd1, 1'b1, 16'd0));
      tbl.push_back(mk(1'b0, 1'b1, 8'h0C, 1'b0, 1'b0, 1'b1, 8'h0A, 2'd2, 1'b0, 16'd1));
      tbl.push_back(mk(1'b0, 1'b1, 8'h0C, 1'b0, 1'b0, 1'b1, 8'h0A, 2'd2, 1'b0, 16'd2));
      tbl.push_back(mk(1'b0, 1'b1, 8'h0C, 1'b1, 1'b0, 1'b1, 8'h0A, 2'd2, 1'b0, 16'd3));
      tbl.push_back(mk(1'b0, 1'b1, 8'h0C, 1'b1, 1'b0, 1'b1, 8'h0B, 2'd1, 1'b1, 16'd3));
      tbl.push_back(mk(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h0C, 2'd1, 1'b1, 16'd3));
      tbl.push_back(mk(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 2'd0, 1'b1, 16'd3));
      // flush at occupancy 2 with in_valid, then flush together with an accept
      tbl.push_back(mk(1'b0, 1'b1, 8'h0D, 1'b0, 1'b0, 1'b0, 8'h00, 2'd0, 1'b1, 16'd3));
      tbl.push_back(mk(1'b0, 1'b1, 8'h0E, 1'b0, 1'b0, 1'b1, 8'h0D, 2'd1, 1'b1, 16'd3));
      tbl.push_back(mk(1'b1, 1'b1, 8'h0F, 1'b0, 1'b0, 1'b1, 8'h0D, 2'd2, 1'b0, 16'd4));
      tbl.push_back(mk(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 2'd0, 1'b1, 16'd5));
      tbl.push_back(mk(1'b0, 1'b1, 8'h11, 1'b0, 1'b0, 1'b0, 8'h00, 2'd0, 1'b1, 16'd5));
      tbl.push_back(mk(1'b1, 1'b1, 8'h12, 1'b1, 1'b0, 1'b1, 8'h11, 2'd1, 1'b1, 16'd5));
      tbl.push_back(mk(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 2'd0, 1'b1, 16'd5));
      tbl.push_back(mk(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 2'd0, 1'b1, 16'd5));
      tbl.push_back(mk(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 2'd0, 1'b1, 16'd0));

      drive_a(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
      b_flush = 1'b0; b_iv = 1'b0; b_din = '0; b_cin = '0; b_ordy = 1'b0; b_clr = 1'b0;

      // power-on reset
      #1 rst = 1'b1;
      #2;
      chk("rst_valid", 128'(a_ov), 128'(1'b0));
      chk("rst_ctrl", 128'(a_cout), 128'(16'h0));
      chk("rst_data", 128'(a_dout), 128'(96'h0));
      chk("rst_occ", 128'(a_occ), 128'(2'd0));
      chk("rst_ready", 128'(a_ir), 128'(1'b1));
      chk("rst_stall", 128'(a_st), 128'(16'd0));
      chk("rst_s0_ready", 128'(b_ir), 128'(1'b1));
      @(negedge clk) rst = 1'b0;

      // directed table
      foreach (tbl[i]) begin
         @(posedge clk); #1;
         drive_a(tbl[i].fl, tbl[i].iv, tbl[i].d, tbl[i].ordy, tbl[i].clr);
         @(negedge clk);
         chk($sformatf("t%0d_valid", i), 128'(a_ov), 128'(tbl[i].ev));
         chk($sformatf("t%0d_occ", i), 128'(a_occ), 128'(tbl[i].eocc));
         chk($sformatf("t%0d_ready", i), 128'(a_ir), 128'(tbl[i].erdy));
         chk($sformatf("t%0d_ctrl", i), 128'(a_cout), 128'(tbl[i].ev ? {8'hC3, tbl[i].ed} : 16'h0));
         if (tbl[i].ev) chk($sformatf("t%0d_data", i), 128'(a_dout), 128'({12{tbl[i].ed}}));
         chk($sformatf("t%0d_stall", i), 128'(a_st), 128'(tbl[i].est));
         chk($sformatf("t%0d_stall4", i), 128'(c_st), 128'(tbl[i].est[3:0]));
      end

      // saturation of the 4-bit counter, then clear during the stall
      @(posedge clk); #1 drive_a(1'b0, 1'b1, 8'h31, 1'b0, 1'b0);
      for (int i = 1; i <= 20; i++) begin
         @(posedge clk); #1 drive_a(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
         @(negedge clk);
         chk($sformatf("sat%0d_c4", i), 128'(c_st), 128'((i - 1 > 15) ? 4'd15 : 4'(i - 1)));
         chk($sformatf("sat%0d_c16", i), 128'(a_st), 128'(16'(i - 1)));
      end
      @(posedge clk); #1 drive_a(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
      @(negedge clk) chk("clr_before", 128'(c_st), 128'(4'd15));
      @(posedge clk); #1 drive_a(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
      @(negedge clk) chk("clr_zero", 128'(c_st), 128'(4'd0));
      chk("clr_zero16", 128'(a_st), 128'(16'd0));
      @(posedge clk); #1 drive_a(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
      @(negedge clk) chk("clr_resume", 128'(c_st), 128'(4'd1));
      chk("sat_entry", 128'(a_dout), 128'({12{8'h31}}));
      @(posedge clk); #1 drive_a(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
      @(negedge clk) chk("sat_drained", 128'(a_occ), 128'(2'd0));

      // asynchronous reset while two entries are held
      @(posedge clk); #1 drive_a(1'b0, 1'b1, 8'h41, 1'b0, 1'b0);
      @(posedge clk); #1 drive_a(1'b0, 1'b1, 8'h42, 1'b0, 1'b0);
      @(posedge clk); #1 drive_a(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
      @(negedge clk) chk("pre_rst_occ", 128'(a_occ), 128'(2'd2));
      #2 rst = 1'b1;
      #1;
      chk("arst_valid", 128'(a_ov), 128'(1'b0));
      chk("arst_ctrl", 128'(a_cout), 128'(16'h0));
      chk("arst_occ", 128'(a_occ), 128'(2'd0));
      chk("arst_stall", 128'(a_st), 128'(16'd0));
      chk("arst_stall4", 128'(c_st), 128'(4'd0));
      chk("arst_ready", 128'(a_ir), 128'(1'b1));
      chk("arst_data", 128'(a_dout), 128'(96'h0));
      @(negedge clk) rst = 1'b0;

      // random traffic, SKID=1 pair, checked against a FIFO model
      sa = 16'd0; sc = 4'd0;
      for (int k = 0; k < 400; k++) begin
         @(posedge clk); #1;
         a_iv = ($urandom_range(0, 3) != 0);
         a_din = {$urandom(), $urandom(), $urandom()};
         a_cin = 16'($urandom());
         a_ordy = ($urandom_range(0, 1) == 1);
         a_flush = ($urandom_range(0, 24) == 0);
         a_clr = ($urandom_range(0, 39) == 0);
         @(negedge clk);
         ev = (qa.size() != 0);
         er = (qa.size() < 2);
         chk("rA_valid", 128'(a_ov), 128'(ev));
         chk("rA_occ", 128'(a_occ), 128'(qa.size()));
         chk("rA_ready", 128'(a_ir), 128'(er));
         chk("rA_ctrl", 128'(a_cout), 128'(ev ? qa[0].c : 16'h0));
         if (ev) chk("rA_data", 128'(a_dout), 128'(qa[0].d));
         chk("rA_stall", 128'(a_st), 128'(sa));
         chk("rC_valid", 128'(c_ov), 128'(ev));
         chk("rC_occ", 128'(c_occ), 128'(qa.size()));
         chk("rC_ready", 128'(c_ir), 128'(er));
         chk("rC_ctrl", 128'(c_cout), 128'(ev ? qa[0].c : 16'h0));
         if (ev) chk("rC_data", 128'(c_dout), 128'(qa[0].d));
         chk("rC_stall4", 128'(c_st), 128'(sc));
         if (a_flush) qa.delete();
         else begin
            if (ev && a_ordy) void'(qa.pop_front());
            if (a_iv && er) qa.push_back('{a_din, a_cin});
         end
         if (a_clr) begin sa = 16'd0; sc = 4'd0; end
         else if (ev && !a_ordy) begin
            if (sa != 16'hFFFF) sa = sa + 16'd1;
            if (sc != 4'hF) sc = sc + 4'd1;
         end
      end
      drive_a(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);

      // random traffic, SKID=0 single-entry build
      sb = 16'd0;
      for (int k = 0; k < 400; k++) begin
         @(posedge clk); #1;
         b_iv = ($urandom_range(0, 3) != 0);
         b_din = {$urandom(), $urandom(), $urandom()};
         b_cin = 16'($urandom());
         b_ordy = ($urandom_range(0, 1) == 1);
         b_flush = ($urandom_range(0, 24) == 0);
         b_clr = ($urandom_range(0, 39) == 0);
         @(negedge clk);
         ev = (qb.size() != 0);
         er = !ev || b_ordy;
         chk("rB_valid", 128'(b_ov), 128'(ev));
         chk("rB_occ", 128'(b_occ), 128'(qb.size()));
         chk("rB_ready", 128'(b_ir), 128'(er));
         chk("rB_ctrl", 128'(b_cout), 128'(ev ? qb[0].c : 16'h0));
         if (ev) chk("rB_data", 128'(b_dout), 128'(qb[0].d));
         chk("rB_stall", 128'(b_st), 128'(sb));
         if (b_flush) qb.delete();
         else begin
            if (ev && b_ordy) void'(qb.pop_front());
            if (b_iv && er) qb.push_back('{b_din, b_cin});
         end
         if (b_clr) sb = 16'd0;
         else if (ev && !b_ordy && sb != 16'hFFFF) sb = sb + 16'd1;
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
